// File: rtl/gated_burst_monitor_pkg.sv
// Shared types and constants for the gated burst monitor.
package gated_burst_pkg;

  // Monitor FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_HIGH      = 3'd3,
    ST_LOW       = 3'd4
  } state_t;

  // Width of the completed-burst counter
  localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/gated_burst_monitor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops to settle metastability
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gated_burst_monitor.sv
// Receive-side checker for a gated burst clock. Measures every high and low
// run of the synchronised waveform, counts pulses per burst, and flags runs
// that deviate from the expected half-period or silence length.
//
// Handshake: there is none. burst_in is a free-running asynchronous level;
// enable is a synchronous level whose 0->1 edge captures the exp_* inputs.
// All event outputs (burst_done, err_high, err_low) are single-cycle pulses.
module gated_burst_monitor
  import gated_burst_pkg::*;
#(
  parameter int DIV_WIDTH    = 10,
  parameter int REP_WIDTH    = 4,
  parameter int PHASE2_WIDTH = 10,
  parameter int RUN_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    burst_in,
  input  logic                    enable,
  input  logic [DIV_WIDTH-1:0]    exp_m1,
  input  logic [PHASE2_WIDTH-1:0] exp_m2,
  input  logic [REP_WIDTH-1:0]    exp_repeat,
  output logic                    burst_done,
  output logic [BURST_CNT_W-1:0]  burst_count,
  output logic                    in_silence,
  output logic                    err_high,
  output logic                    err_low,
  output logic                    err_sticky,
  output logic                    cfg_invalid,
  output logic [RUN_WIDTH-1:0]    last_high_len,
  output logic [RUN_WIDTH-1:0]    last_low_len,
  output state_t                  dbg_state
);

  // Synchronised waveform and edge detection
  logic w_sync;
  logic r_sync_d;
  logic w_rise;
  logic w_fall;

  // Enable edge detection
  logic r_en_d;
  logic w_en_rise;

  // Captured configuration
  logic [DIV_WIDTH-1:0]    r_m1;
  logic [PHASE2_WIDTH-1:0] r_m2;
  logic [REP_WIDTH-1:0]    r_rep;

  // Run measurement and burst tracking
  state_t                 r_state;
  logic [RUN_WIDTH-1:0]   r_run;
  logic                   r_flagged;
  logic [REP_WIDTH-1:0]   r_pulse_cnt;
  logic                   r_gap;

  // Registered outputs
  logic                   r_burst_done;
  logic [BURST_CNT_W-1:0] r_burst_count;
  logic                   r_in_silence;
  logic                   r_err_high;
  logic                   r_err_low;
  logic                   r_err_sticky;
  logic                   r_cfg_invalid;
  logic [RUN_WIDTH-1:0]   r_last_high;
  logic [RUN_WIDTH-1:0]   r_last_low;

  // Derived helpers
  logic [RUN_WIDTH-1:0]   w_exp_high;
  logic [RUN_WIDTH-1:0]   w_exp_low;
  logic [RUN_WIDTH-1:0]   w_run_inc;
  logic [REP_WIDTH-1:0]   w_pulse_next;
  logic                   w_burst_end;

  sync_2ff u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (burst_in),
    .o_q   (w_sync)
  );

  assign w_rise    = w_sync & ~r_sync_d;
  assign w_fall    = ~w_sync & r_sync_d;
  assign w_en_rise = enable & ~r_en_d;

  assign w_exp_high   = RUN_WIDTH'(r_m1);
  assign w_exp_low    = r_gap ? RUN_WIDTH'(r_m2) : RUN_WIDTH'(r_m1);
  // Saturate rather than wrap so an absurdly long run cannot alias a short one
  assign w_run_inc    = (r_run == {RUN_WIDTH{1'b1}}) ? r_run : r_run + 1'b1;
  assign w_pulse_next = r_pulse_cnt + 1'b1;
  assign w_burst_end  = (r_rep != '0) && (w_pulse_next == r_rep);

  // Edge-detect delay flops; kept running even while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_d <= 1'b0;
      r_en_d   <= 1'b0;
    end else begin
      r_sync_d <= w_sync;
      r_en_d   <= enable;
    end
  end

  // Monitor FSM: configuration capture, run measurement and error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_m1          <= '0;
      r_m2          <= '0;
      r_rep         <= '0;
      r_run         <= '0;
      r_flagged     <= 1'b0;
      r_pulse_cnt   <= '0;
      r_gap         <= 1'b0;
      r_burst_done  <= 1'b0;
      r_burst_count <= '0;
      r_in_silence  <= 1'b0;
      r_err_high    <= 1'b0;
      r_err_low     <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_cfg_invalid <= 1'b0;
      r_last_high   <= '0;
      r_last_low    <= '0;
    end else begin
      r_burst_done <= 1'b0;
      r_err_high   <= 1'b0;
      r_err_low    <= 1'b0;
      if (!enable) begin
        // Disable acts as a synchronous clear and takes priority over any edge
        r_state       <= ST_IDLE;
        r_m1          <= '0;
        r_m2          <= '0;
        r_rep         <= '0;
        r_run         <= '0;
        r_flagged     <= 1'b0;
        r_pulse_cnt   <= '0;
        r_gap         <= 1'b0;
        r_burst_count <= '0;
        r_in_silence  <= 1'b0;
        r_err_sticky  <= 1'b0;
        r_cfg_invalid <= 1'b0;
        r_last_high   <= '0;
        r_last_low    <= '0;
      end else if (w_en_rise) begin
        r_m1          <= exp_m1;
        r_m2          <= exp_m2;
        r_rep         <= exp_repeat;
        r_cfg_invalid <= (exp_m1 == '0);
        r_state       <= (exp_m1 == '0) ? ST_IDLE : ST_ARM;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          // Skip any high run already in progress when enable arrived
          ST_ARM: begin
            if (!w_sync) r_state <= ST_WAIT_RISE;
          end
          ST_WAIT_RISE: begin
            if (w_rise) begin
              r_state   <= ST_HIGH;
              r_run     <= RUN_WIDTH'(1);
              r_flagged <= 1'b0;
            end
          end
          ST_HIGH: begin
            if (w_fall) begin
              r_last_high <= r_run;
              if ((r_run != w_exp_high) && !r_flagged) begin
                r_err_high   <= 1'b1;
                r_err_sticky <= 1'b1;
              end
              r_state   <= ST_LOW;
              r_run     <= RUN_WIDTH'(1);
              r_flagged <= 1'b0;
              if (w_burst_end) begin
                r_burst_done  <= 1'b1;
                r_burst_count <= r_burst_count + 1'b1;
                r_pulse_cnt   <= '0;
                r_gap         <= (r_m2 != '0);
                r_in_silence  <= (r_m2 != '0);
              end else begin
                r_pulse_cnt  <= w_pulse_next;
                r_gap        <= 1'b0;
                r_in_silence <= 1'b0;
              end
            end else begin
              r_run <= w_run_inc;
              // Run is about to exceed the expected length: report once, now
              if ((r_run == w_exp_high) && !r_flagged) begin
                r_err_high   <= 1'b1;
                r_err_sticky <= 1'b1;
                r_flagged    <= 1'b1;
              end
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_last_low <= r_run;
              if ((r_run != w_exp_low) && !r_flagged) begin
                r_err_low    <= 1'b1;
                r_err_sticky <= 1'b1;
              end
              r_state      <= ST_HIGH;
              r_run        <= RUN_WIDTH'(1);
              r_flagged    <= 1'b0;
              r_gap        <= 1'b0;
              r_in_silence <= 1'b0;
            end else begin
              r_run <= w_run_inc;
              if ((r_run == w_exp_low) && !r_flagged) begin
                r_err_low    <= 1'b1;
                r_err_sticky <= 1'b1;
                r_flagged    <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign burst_done    = r_burst_done;
  assign burst_count   = r_burst_count;
  assign in_silence    = r_in_silence;
  assign err_high      = r_err_high;
  assign err_low       = r_err_low;
  assign err_sticky    = r_err_sticky;
  assign cfg_invalid   = r_cfg_invalid;
  assign last_high_len = r_last_high;
  assign last_low_len  = r_last_low;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_gated_burst_monitor.sv
// Self-checking bench for gated_burst_monitor. Waveforms are described as
// lists of run lengths; a run-level reference model derives the expected
// event pulses per synchronised sample from those lengths.
module tb_gated_burst_monitor;
  import gated_burst_pkg::*;

  localparam int MAXS = 600;
  localparam int PRE  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        burst_in = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  exp_m1 = '0;
  logic [9:0]  exp_m2 = '0;
  logic [3:0]  exp_repeat = '0;
  logic        burst_done;
  logic [15:0] burst_count;
  logic        in_silence;
  logic        err_high;
  logic        err_low;
  logic        err_sticky;
  logic        cfg_invalid;
  logic [11:0] last_high_len;
  logic [11:0] last_low_len;
  state_t      dbg_state;

  int n_pass = 0;
  int n_total = 0;

  int runs_q[$];
  bit pin_a  [MAXS];
  bit e_done [MAXS];
  bit e_eh   [MAXS];
  bit e_el   [MAXS];
  bit e_sil  [MAXS];

  gated_burst_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .burst_in      (burst_in),
    .enable        (enable),
    .exp_m1        (exp_m1),
    .exp_m2        (exp_m2),
    .exp_repeat    (exp_repeat),
    .burst_done    (burst_done),
    .burst_count   (burst_count),
    .in_silence    (in_silence),
    .err_high      (err_high),
    .err_low       (err_low),
    .err_sticky    (err_sticky),
    .cfg_invalid   (cfg_invalid),
    .last_high_len (last_high_len),
    .last_low_len  (last_low_len),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: hold burst_in at a level for n cycles
  task automatic drive_level(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      burst_in = v;
    end
  endtask

  // Random run-length perturbation
  function automatic int pert();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return -1;
    if (r == 1) return 1;
    if (r == 2) return 3;
    return 0;
  endfunction

  // Play runs_q (alternating high/low, first high, final run open-ended)
  // and compare every cycle against the run-level model, then drop enable.
  task automatic run_wave(input string name, input int m1, input int m2, input int rep);
    int pos, n, pulses, bursts, lhl, lll, s;
    bit gap, any_err, last;
    for (int i = 0; i < MAXS; i++) begin
      pin_a[i] = 0; e_done[i] = 0; e_eh[i] = 0; e_el[i] = 0; e_sil[i] = 0;
    end
    pos = PRE; pulses = 0; bursts = 0; lhl = 0; lll = 0; gap = 0;
    for (int k = 0; k < runs_q.size(); k++) begin
      int len, ex;
      len  = runs_q[k];
      last = (k == runs_q.size() - 1);
      if (k % 2 == 0) begin
        for (int i = 0; i < len; i++) pin_a[pos + i] = 1;
        if (len > m1) e_eh[pos + m1] = 1;
        else if (len < m1 && !last) e_eh[pos + len] = 1;
        if (!last) begin
          lhl = len;
          pulses++;
          gap = 0;
          if (rep != 0 && pulses == rep) begin
            e_done[pos + len] = 1;
            bursts++;
            pulses = 0;
            gap = (m2 != 0);
          end
        end
      end else begin
        ex = gap ? m2 : m1;
        for (int i = 0; i < len; i++) e_sil[pos + i] = gap;
        if (len > ex) e_el[pos + ex] = 1;
        else if (len < ex && !last) e_el[pos + len] = 1;
        if (!last) lll = len;
        gap = 0;
      end
      pos += len;
    end
    n = pos;
    any_err = 0;
    for (int i = 0; i < n; i++) any_err |= e_eh[i] | e_el[i];

    // Flush the sync chain low with the monitor disabled
    @(negedge clk);
    enable = 0; burst_in = 0;
    exp_m1 = 10'(m1); exp_m2 = 10'(m2); exp_repeat = 4'(rep);
    repeat (3) @(negedge clk);

    for (int j = 0; j < n + 2; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) enable = 1;
      burst_in = (j < n) ? pin_a[j] : 1'b0;
      @(posedge clk);
      #1;
      if (j >= 2) begin
        s = j - 2;
        n_total++;
        if (burst_done !== e_done[s])
          $display("FAIL %s burst_done sample %0d: got %b want %b", name, s, burst_done, e_done[s]);
        else n_pass++;
        n_total++;
        if (err_high !== e_eh[s])
          $display("FAIL %s err_high sample %0d: got %b want %b", name, s, err_high, e_eh[s]);
        else n_pass++;
        n_total++;
        if (err_low !== e_el[s])
          $display("FAIL %s err_low sample %0d: got %b want %b", name, s, err_low, e_el[s]);
        else n_pass++;
        n_total++;
        if (in_silence !== e_sil[s])
          $display("FAIL %s in_silence sample %0d: got %b want %b", name, s, in_silence, e_sil[s]);
        else n_pass++;
      end
    end

    n_total++;
    if (burst_count !== 16'(bursts))
      $display("FAIL %s burst_count: got %0d want %0d", name, burst_count, bursts);
    else n_pass++;
    n_total++;
    if (err_sticky !== any_err)
      $display("FAIL %s err_sticky: got %b want %b", name, err_sticky, any_err);
    else n_pass++;
    n_total++;
    if (last_high_len !== 12'(lhl))
      $display("FAIL %s last_high_len: got %0d want %0d", name, last_high_len, lhl);
    else n_pass++;
    n_total++;
    if (last_low_len !== 12'(lll))
      $display("FAIL %s last_low_len: got %0d want %0d", name, last_low_len, lll);
    else n_pass++;
    n_total++;
    if (cfg_invalid !== 1'b0)
      $display("FAIL %s cfg_invalid: got %b want 0", name, cfg_invalid);
    else n_pass++;

    // Drop enable; this edge may coincide with a fall, which must be ignored
    @(negedge clk);
    enable = 0;
    @(posedge clk);
    #1;
    n_total++;
    if ({burst_done, err_high, err_low, in_silence, err_sticky, cfg_invalid} !== 6'b0 ||
        burst_count !== 16'd0 || last_high_len !== 12'd0 || last_low_len !== 12'd0)
      $display("FAIL %s clear_on_disable: got flags=%b cnt=%0d hl=%0d ll=%0d want all 0", name,
               {burst_done, err_high, err_low, in_silence, err_sticky, cfg_invalid},
               burst_count, last_high_len, last_low_len);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1; enable = 0; burst_in = 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({burst_done, err_high, err_low, in_silence, err_sticky, cfg_invalid} !== 6'b0 ||
        burst_count !== 16'd0 || last_high_len !== 12'd0 || last_low_len !== 12'd0)
      $display("FAIL reset_outputs: got flags=%b cnt=%0d want all 0",
               {burst_done, err_high, err_low, in_silence, err_sticky, cfg_invalid}, burst_count);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_IDLE)
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_burst_silence;
    runs_q.delete();
    for (int b = 0; b < 3; b++) begin
      for (int p = 0; p < 4; p++) begin
        runs_q.push_back(3);
        runs_q.push_back((p == 3) ? 5 : 3);
      end
    end
    run_wave("burst_m1_3_m2_5_rep4", 3, 5, 4);
  endtask

  task automatic test_continuous_rep2;
    runs_q.delete();
    for (int p = 0; p < 6; p++) begin
      runs_q.push_back(2);
      runs_q.push_back(2);
    end
    run_wave("cont_m1_2_rep2", 2, 0, 2);
  endtask

  task automatic test_rep0;
    runs_q.delete();
    for (int p = 0; p < 5; p++) begin
      runs_q.push_back(4);
      runs_q.push_back(4);
    end
    run_wave("rep0_m1_4", 4, 0, 0);
  endtask

  task automatic test_err_high;
    runs_q = '{3, 3, 3, 3, 4, 3};
    run_wave("err_high_len4", 3, 0, 0);
  endtask

  task automatic test_silence_stall;
    runs_q = '{3, 3, 3, 20, 3, 3};
    run_wave("silence_stall", 3, 6, 2);
  endtask

  // Ends mid-high so that the disable edge lands on a fall with rep=1
  task automatic test_enable_drop;
    runs_q = '{2, 2, 2, 2, 3, 2, 2};
    run_wave("enable_drop_mid_high", 2, 0, 1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int m1, m2, rep, np, pc;
      m1 = $urandom_range(2, 6);
      m2 = $urandom_range(0, 8);
      rep = $urandom_range(0, 4);
      np = $urandom_range(4, 10);
      pc = 0;
      runs_q.delete();
      for (int k = 0; k < np; k++) begin
        int h, l, ex;
        h = m1 + pert();
        if (h < 1) h = 1;
        pc++;
        ex = m1;
        if (rep != 0 && pc == rep) begin
          pc = 0;
          if (m2 != 0) ex = m2;
        end
        if (k == np - 1) l = $urandom_range(1, ex);
        else l = ex + pert();
        if (l < 1) l = 1;
        runs_q.push_back(h);
        runs_q.push_back(l);
      end
      run_wave($sformatf("random%0d", it), m1, m2, rep);
    end
  endtask

  task automatic test_cfg_invalid;
    int bad;
    bad = 0;
    @(negedge clk);
    enable = 0; burst_in = 0;
    exp_m1 = 10'd0; exp_m2 = 10'd3; exp_repeat = 4'd2;
    repeat (3) @(negedge clk);
    enable = 1;
    for (int p = 0; p < 4; p++) begin
      repeat (3) begin
        @(negedge clk); burst_in = 1;
        @(posedge clk); #1;
        if ({burst_done, err_high, err_low, in_silence, err_sticky} !== 5'b0) bad++;
      end
      repeat (3) begin
        @(negedge clk); burst_in = 0;
        @(posedge clk); #1;
        if ({burst_done, err_high, err_low, in_silence, err_sticky} !== 5'b0) bad++;
      end
    end
    n_total++;
    if (bad != 0)
      $display("FAIL cfg_invalid_no_events: got %0d event cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (cfg_invalid !== 1'b1)
      $display("FAIL cfg_invalid_flag: got %b want 1", cfg_invalid);
    else n_pass++;
    n_total++;
    if (burst_count !== 16'd0 || last_high_len !== 12'd0)
      $display("FAIL cfg_invalid_counts: got cnt=%0d hl=%0d want 0", burst_count, last_high_len);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_IDLE)
      $display("FAIL cfg_invalid_state: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    @(negedge clk);
    enable = 0;
    @(posedge clk); #1;
    n_total++;
    if (cfg_invalid !== 1'b0)
      $display("FAIL cfg_invalid_clear: got %b want 0", cfg_invalid);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    enable = 0; burst_in = 0;
    exp_m1 = 10'd2; exp_m2 = 10'd0; exp_repeat = 4'd1;
    repeat (3) @(negedge clk);
    enable = 1;
    drive_level(0, 4);
    drive_level(1, 6);
    drive_level(0, 4);
    @(posedge clk); #1;
    n_total++;
    if (err_sticky !== 1'b1 || burst_count !== 16'd1 || last_high_len !== 12'd6)
      $display("FAIL pre_reset_state: got sticky=%b cnt=%0d hl=%0d want 1/1/6",
               err_sticky, burst_count, last_high_len);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_total++;
    if ({burst_done, err_high, err_low, in_silence, err_sticky, cfg_invalid} !== 6'b0 ||
        burst_count !== 16'd0 || last_high_len !== 12'd0 || last_low_len !== 12'd0)
      $display("FAIL async_reset_clear: got flags=%b cnt=%0d want all 0",
               {burst_done, err_high, err_low, in_silence, err_sticky, cfg_invalid}, burst_count);
    else n_pass++;
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    n_total++;
    if (dbg_state !== ST_ARM)
      $display("FAIL rearm_after_reset: got %0d want %0d", dbg_state, ST_ARM);
    else n_pass++;
    @(negedge clk);
    enable = 0;
  endtask

  // Watchdog so the bench always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst_silence();
    test_continuous_rep2();
    test_rep0();
    test_err_high();
    test_silence_stall();
    test_enable_drop();
    test_random();
    test_cfg_invalid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
